// File: rtl/array_22_pkg.sv
// Shared constants and types for the array_22 request front-end.
package array_22_pkg;

  localparam int ADDR_W     = 12;  // 4096 rows
  localparam int DATA_W     = 96;  // row width
  localparam int MASK_W     = 16;  // byte-lane enables, 6 bits per lane
  localparam int STARVE_LIM = 4;   // reads a buffered write may lose to before it is forced
  localparam int STARVE_W   = $clog2(STARVE_LIM + 1);

  // One buffered write request.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } wr_req_t;

  // What the single RW0 port does this cycle.
  typedef enum logic [1:0] {
    OP_IDLE,
    OP_READ,
    OP_WRITE
  } rw_op_e;

endpackage

// File: rtl/array_22_req_ctrl_if.sv
// Request/response streams between the owning pipeline stage and the front-end.
interface array_22_req_ctrl_if;
  import array_22_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  // Requester side: issues reads/writes, consumes responses.
  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, resp_ready,
    input  wr_ready, rd_ready, resp_valid, resp_data
  );

  // Front-end side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, resp_ready,
    output wr_ready, rd_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/array_22_resp_fifo.sv
// Two-entry read-response FIFO. Upstream credit logic guarantees it never
// overflows and is never popped while empty.
module array_22_resp_fifo
  import array_22_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage.
  // NOTE: payload storage is not reset; cnt alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/array_22_req_ctrl.sv
// Request front-end for array_22: arbitrates independent read and write streams
// onto the single RW0 port, holds one pending write, and returns read data in
// order through a 2-entry response FIFO.
module array_22_req_ctrl
  import array_22_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  array_22_req_ctrl_if.slave req,
  output logic [ADDR_W-1:0]  RW0_addr,
  output logic               RW0_en,
  output logic               RW0_wmode,
  output logic [DATA_W-1:0]  RW0_wdata,
  output logic [MASK_W-1:0]  RW0_wmask,
  input  logic [DATA_W-1:0]  RW0_rdata
);

  wr_req_t               wbuf;
  logic                  wbuf_v;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  inflight;
  logic                  started;
  logic [1:0]            fifo_cnt;
  logic [2:0]            credit_use;
  logic                  resp_fire;
  logic                  rd_ok;
  logic                  rd_hit;
  logic                  force_wr;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  wbuf_issue;
  rw_op_e                op;

  assign resp_fire      = req.resp_valid & req.resp_ready;
  assign req.resp_valid = (fifo_cnt != 2'd0);

  // A read may be accepted only if its response is guaranteed a FIFO slot.
  assign credit_use = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, resp_fire};
  assign rd_ok      = (credit_use < 3'd2);

  // Reads to the buffered write's row wait until that write has reached the array.
  assign rd_hit   = wbuf_v & (wbuf.addr == req.rd_addr);
  assign force_wr = wbuf_v & (starve_cnt == STARVE_W'(STARVE_LIM));

  assign req.rd_ready = started & rd_ok & ~rd_hit & ~force_wr;
  assign rd_fire      = req.rd_valid & req.rd_ready;

  assign wbuf_issue   = (op == OP_WRITE);
  assign req.wr_ready = ~wbuf_v | wbuf_issue;
  assign wr_fire      = req.wr_valid & req.wr_ready;

  // Port arbitration and RW0 drive: forced write, then read, then buffered write.
  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    op        = OP_IDLE;
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    RW0_wmask = '0;
    if (force_wr)     op = OP_WRITE;
    else if (rd_fire) op = OP_READ;
    else if (wbuf_v)  op = OP_WRITE;
    case (op)
      OP_READ: begin
        RW0_en   = 1'b1;
        RW0_addr = req.rd_addr;
      end
      OP_WRITE: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = wbuf.addr;
        RW0_wdata = wbuf.data;
        RW0_wmask = wbuf.mask;
      end
      default: ;
    endcase
  end

  // Holds rd_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) started <= 1'b0;
    else        started <= 1'b1;
  end

  // Write-buffer occupancy, starvation counter and read-in-flight flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_v     <= 1'b0;
      starve_cnt <= '0;
      inflight   <= 1'b0;
    end else begin
      inflight <= rd_fire;
      if (wr_fire)         wbuf_v <= 1'b1;
      else if (wbuf_issue) wbuf_v <= 1'b0;
      if (wbuf_issue)
        starve_cnt <= '0;
      else if (wbuf_v && rd_fire && (starve_cnt != STARVE_W'(STARVE_LIM)))
        starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Write-buffer payload; only meaningful while wbuf_v is set.
  always_ff @(posedge clk) begin
    if (wr_fire) wbuf <= '{addr: req.wr_addr, data: req.wr_data, mask: req.wr_mask};
  end

  // Read data arrives the cycle after issue and is queued for the consumer.
  array_22_resp_fifo u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (RW0_rdata),
    .pop       (resp_fire),
    .head      (req.resp_data),
    .cnt       (fifo_cnt)
  );

endmodule

// File: tb/tb_array_22_req_ctrl.sv
// Self-checking bench for array_22_req_ctrl: directed scenarios plus a random
// phase, every cycle compared against a transaction-level reference model.
module tb_array_22_req_ctrl;
  import array_22_pkg::*;

  localparam int LANE_W = DATA_W / MASK_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  array_22_req_ctrl_if bus ();

  logic [ADDR_W-1:0] rw0_addr;
  logic              rw0_en;
  logic              rw0_wmode;
  logic [DATA_W-1:0] rw0_wdata;
  logic [MASK_W-1:0] rw0_wmask;
  logic [DATA_W-1:0] rw0_rdata = '0;

  array_22_req_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus),
    .RW0_addr  (rw0_addr),
    .RW0_en    (rw0_en),
    .RW0_wmode (rw0_wmode),
    .RW0_wdata (rw0_wdata),
    .RW0_wmask (rw0_wmask),
    .RW0_rdata (rw0_rdata)
  );

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_row,
                                                    input logic [DATA_W-1:0] new_row,
                                                    input logic [MASK_W-1:0] mask);
    logic [DATA_W-1:0] r;
    r = old_row;
    for (int i = 0; i < MASK_W; i++)
      if (mask[i]) r[i*LANE_W +: LANE_W] = new_row[i*LANE_W +: LANE_W];
    return r;
  endfunction

  // Stand-in for array_22: one-cycle read latency, garbage on rdata otherwise.
  logic [DATA_W-1:0] arr_mem [4096] = '{default: '0};
  always @(posedge clk) begin
    if (rw0_en && rw0_wmode)
      arr_mem[rw0_addr] <= merge_lanes(arr_mem[rw0_addr], rw0_wdata, rw0_wmask);
    if (rw0_en && !rw0_wmode) rw0_rdata <= arr_mem[rw0_addr];
    else                      rw0_rdata <= {$urandom(), $urandom(), $urandom()};
  end

  // Reference model: row contents, one pending write with its lost-arbitration
  // count, and outstanding read responses with the cycle each becomes visible.
  logic [DATA_W-1:0] ref_mem [4096] = '{default: '0};
  logic              pend_v    = 1'b0;
  wr_req_t           pend      = '0;
  int                pend_loss = 0;
  logic              started   = 1'b0;
  logic [DATA_W-1:0] exp_q [$];
  int                rdy_q [$];
  int                cyc   = 0;
  int                n_vec = 0;
  int                n_err = 0;

  logic              obs_rd_ready, obs_wr_issue, obs_resp_valid;
  logic [DATA_W-1:0] obs_resp_data;
  logic              last_rd_fire, last_wr_acc;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check1("rst_wr_ready",   bus.wr_ready,   1'b1);
    check1("rst_rd_ready",   bus.rd_ready,   1'b0);
    check1("rst_resp_valid", bus.resp_valid, 1'b0);
    check1("rst_rw0_en",     rw0_en,         1'b0);
    check1("rst_rw0_wmode",  rw0_wmode,      1'b0);
    check("rst_rw0_addr",  DATA_W'(rw0_addr),  '0);
    check("rst_rw0_wdata", rw0_wdata,          '0);
    check("rst_rw0_wmask", DATA_W'(rw0_wmask), '0);
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge, advance the model.
  task automatic tick(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic [MASK_W-1:0] wm, input logic rv, input logic [ADDR_W-1:0] ra,
                      input logic rr);
    logic ev, rf, force_w, hit, erdy, rdf, wis, ewr;
    int outstanding;
    logic [ADDR_W-1:0] eaddr;
    bus.wr_valid   = wv;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.wr_mask    = wm;
    bus.rd_valid   = rv;
    bus.rd_addr    = ra;
    bus.resp_ready = rr;
    @(negedge clk);
    obs_rd_ready   = bus.rd_ready;
    obs_wr_issue   = rw0_en & rw0_wmode;
    obs_resp_valid = bus.resp_valid;
    obs_resp_data  = bus.resp_data;
    last_rd_fire   = 1'b0;
    last_wr_acc    = 1'b0;
    if (!rst_n) begin
      check_reset_outputs();
    end else begin
      outstanding = exp_q.size();
      ev      = (outstanding > 0) && (rdy_q[0] <= cyc);
      rf      = ev && rr;
      force_w = pend_v && (pend_loss >= STARVE_LIM);
      hit     = pend_v && (pend.addr == ra);
      erdy    = started && ((outstanding - (rf ? 1 : 0)) < 2) && !hit && !force_w;
      rdf     = rv && erdy;
      wis     = pend_v && !rdf;
      ewr     = !pend_v || wis;
      eaddr   = rdf ? ra : (wis ? pend.addr : '0);
      check1("wr_ready",   bus.wr_ready,   ewr);
      check1("rd_ready",   bus.rd_ready,   erdy);
      check1("resp_valid", bus.resp_valid, ev);
      if (ev) check("resp_data", bus.resp_data, exp_q[0]);
      check1("rw0_en",    rw0_en,    rdf || wis);
      check1("rw0_wmode", rw0_wmode, wis);
      check("rw0_addr", DATA_W'(rw0_addr), DATA_W'(eaddr));
      if (!rdf) begin
        check("rw0_wdata", rw0_wdata,          wis ? pend.data : '0);
        check("rw0_wmask", DATA_W'(rw0_wmask), wis ? DATA_W'(pend.mask) : '0);
      end
      if (rf) begin
        void'(exp_q.pop_front());
        void'(rdy_q.pop_front());
      end
      if (rdf) begin
        exp_q.push_back(ref_mem[ra]);
        rdy_q.push_back(cyc + 2);
      end
      if (wis) begin
        ref_mem[pend.addr] = merge_lanes(ref_mem[pend.addr], pend.data, pend.mask);
        pend_v    = 1'b0;
        pend_loss = 0;
      end else if (pend_v && rdf) begin
        pend_loss++;
      end
      if (wv && ewr) begin
        pend      = '{addr: wa, data: wd, mask: wm};
        pend_v    = 1'b1;
        pend_loss = 0;
      end
      last_rd_fire = rdf;
      last_wr_acc  = wv && ewr;
      started      = 1'b1;
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic write_req(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [MASK_W-1:0] m);
    tick(1'b1, a, d, m, 1'b0, '0, 1'b1);
  endtask

  // Hold a read request until accepted; n = cycles taken (bounded).
  task automatic read_until(input logic [ADDR_W-1:0] a, output int n);
    n = 0;
    last_rd_fire = 1'b0;
    while (!last_rd_fire && n < 8) begin
      tick(1'b0, '0, '0, '0, 1'b1, a, 1'b1);
      n++;
    end
  endtask

  // Wait (bounded) for the next response; lat = idle cycles before it showed.
  task automatic await_resp(output logic [DATA_W-1:0] d, output int lat, output logic got);
    got = 1'b0;
    d   = '0;
    lat = -1;
    for (int k = 0; k < 6 && !got; k++) begin
      idle(1);
      if (obs_resp_valid) begin
        got = 1'b1;
        d   = obs_resp_data;
        lat = k;
      end
    end
  endtask

  task automatic apply_reset();
    bus.wr_valid   = 1'b0;
    bus.rd_valid   = 1'b0;
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    pend_v    = 1'b0;
    pend_loss = 0;
    started   = 1'b0;
    exp_q.delete();
    rdy_q.delete();
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] lane0_row;
    logic              got, seen;
    int                n, lat, first, acc;
    logic              cw_v, cr_v, rr;
    logic [ADDR_W-1:0] cw_a, cr_a;
    logic [DATA_W-1:0] cw_d;
    logic [MASK_W-1:0] cw_m;

    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.wr_mask    = '0;
    bus.rd_valid   = 1'b0;
    bus.rd_addr    = '0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Write then read of the same row.
    pat_a5 = {12{8'hA5}};
    write_req(12'h005, pat_a5, 16'hFFFF);
    read_until(12'h005, n);
    check("wr_then_rd_wait", DATA_W'(n), DATA_W'(2));
    await_resp(d, lat, got);
    check1("wr_then_rd_got", got, 1'b1);
    check("wr_then_rd_data", d, pat_a5);
    check("wr_then_rd_latency", DATA_W'(lat), DATA_W'(1));

    // Read blocked by a buffered write to the same row, then sees new data.
    write_req(12'h123, {3{32'hC0DE_1234}}, 16'hFFFF);
    read_until(12'h123, n);
    check("hazard_wait", DATA_W'(n), DATA_W'(2));
    await_resp(d, lat, got);
    check("hazard_data", d, {3{32'hC0DE_1234}});

    // Read pressure every cycle; the queued write must be forced through.
    tick(1'b1, 12'h200, {3{32'h5A5A_0F0F}}, 16'hFFFF, 1'b1, 12'h201, 1'b1);
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b0, '0, '0, '0, 1'b1, ADDR_W'(12'h201 + i), 1'b1);
      if (obs_wr_issue && first == 0) first = i;
    end
    check("starve_issue_cycle", DATA_W'(first), DATA_W'(STARVE_LIM + 1));
    idle(4);

    // Backpressure: only two reads may be outstanding.
    acc = 0;
    n   = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, '0, '0, n < 4, ADDR_W'(12'h400 + n), 1'b0);
      if (n < 4 && obs_rd_ready) acc++;
      if (last_rd_fire) n++;
    end
    check("bp_accepted", DATA_W'(acc), DATA_W'(2));
    check1("bp_rd_ready_low", obs_rd_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, '0, '0, '0, n < 4, ADDR_W'(12'h400 + n), 1'b1);
      if (last_rd_fire) n++;
    end
    check("bp_all_accepted", DATA_W'(n), DATA_W'(4));
    idle(3);

    // Partial mask: only lane 0 of an all-ones row is overwritten.
    lane0_row = {{(DATA_W-LANE_W){1'b1}}, {LANE_W{1'b0}}};
    write_req(12'h300, {DATA_W{1'b1}}, 16'hFFFF);
    idle(1);
    write_req(12'h300, '0, 16'h0001);
    idle(1);
    read_until(12'h300, n);
    await_resp(d, lat, got);
    check("mask_lane0", d, lane0_row);

    // Random traffic on a few rows so hazards and backpressure interleave.
    cw_v = 1'b0; cw_a = '0; cw_d = '0; cw_m = '0;
    cr_v = 1'b0; cr_a = '0;
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(3) != 0);
      tick(cw_v, cw_a, cw_d, cw_m, cr_v, cr_a, rr);
      if (!cw_v || last_wr_acc) begin
        cw_v = ($urandom_range(1) == 1);
        cw_a = ADDR_W'($urandom_range(7));
        cw_d = {$urandom(), $urandom(), $urandom()};
        cw_m = MASK_W'($urandom());
      end
      if (!cr_v || last_rd_fire) begin
        cr_v = ($urandom_range(2) != 0);
        cr_a = ADDR_W'($urandom_range(7));
      end
    end
    idle(4);

    // Reset with a read in flight and a write buffered: both are discarded.
    tick(1'b1, 12'h010, {3{32'hDEAD_BEEF}}, 16'hFFFF, 1'b1, 12'h011, 1'b1);
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      seen = seen | obs_resp_valid;
    end
    check1("rst_resp_never", seen, 1'b0);
    read_until(12'h010, n);
    await_resp(d, lat, got);
    check("rst_write_dropped", d, '0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
